inst_encode: RTL and testbench

INST_ENCODE -- requirements
Module: inst_encode

---
 rtl/inst_encode.sv | 210 +++++++++++++++++++++
 tb/tb_inst_encode.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_encode.sv
// inst_encode: turns internal micro-ops into 32-bit instruction words.
// Each accepted micro-op is encoded combinationally, flagged if its opcode
// or immediate is illegal, and queued in a small circular output FIFO
// together with its warp id and tlast sideband.
module inst_encode #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [7:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic [4:0]  warp_id_in,
  input  logic        s_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] instruction,
  output logic [4:0]  warp_id_out,
  output logic        m_tlast,
  output logic        m_terr,
  output logic [31:0] err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic        terr;
    logic        tlast;
    logic [4:0]  warp;
    logic [31:0] word;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      err_q, err_d;
  entry_t           out_q, out_d;
  entry_t           rd_arr [DEPTH];

  logic [31:0] enc_word;
  logic [2:0]  f3;
  logic [6:0]  funct7;
  logic        op_bad;
  logic        imm_bad;
  entry_t      new_entry;
  logic        push;
  logic        pop;

  // funct3 per internal opcode; opcodes without a funct3 field return 0
  function automatic logic [2:0] funct3_of(input logic [7:0] op);
    logic [2:0] r;
    case (op)
      8'd0:  r = 3'b000;  8'd1:  r = 3'b001;  8'd2:  r = 3'b100;
      8'd3:  r = 3'b101;  8'd4:  r = 3'b110;  8'd5:  r = 3'b111;
      8'd6:  r = 3'b000;  8'd7:  r = 3'b001;  8'd8:  r = 3'b010;
      8'd9:  r = 3'b100;  8'd10: r = 3'b101;
      8'd11: r = 3'b000;  8'd12: r = 3'b001;  8'd13: r = 3'b010;
      8'd14: r = 3'b000;  8'd15: r = 3'b010;  8'd16: r = 3'b011;
      8'd17: r = 3'b100;  8'd18: r = 3'b110;  8'd19: r = 3'b111;
      8'd20: r = 3'b001;  8'd21: r = 3'b101;  8'd22: r = 3'b101;
      8'd23: r = 3'b000;  8'd24: r = 3'b000;  8'd25: r = 3'b001;
      8'd26: r = 3'b010;  8'd27: r = 3'b011;  8'd28: r = 3'b100;
      8'd29: r = 3'b101;  8'd30: r = 3'b101;  8'd31: r = 3'b110;
      8'd32: r = 3'b111;
      8'd33: r = 3'b000;  8'd34: r = 3'b001;  8'd35: r = 3'b010;
      8'd37: r = 3'b000;
      8'd40: r = 3'b101;  8'd41: r = 3'b110;  8'd42: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // Encoder and legality check, purely combinational on the input fields
  always_comb begin
    enc_word = '0;
    op_bad   = 1'b0;
    imm_bad  = 1'b0;
    f3       = funct3_of(opcode);
    funct7   = '0;
    if (opcode <= 8'd5) begin
      enc_word = {imm[23:18], imm[7], rs2, rs1, f3, imm[6:2], 7'b1100011};
      imm_bad  = (|imm[31:24]) | (|imm[17:8]) | (|imm[1:0]);
    end else if (opcode <= 8'd10) begin
      enc_word = {imm[11:0], rs1, f3, rd, 7'b0000011};
      imm_bad  = |imm[31:12];
    end else if (opcode <= 8'd13) begin
      enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      imm_bad  = |imm[31:12];
    end else if (opcode <= 8'd22) begin
      if (opcode == 8'd22) begin
        funct7  = 7'b0100000;
        // arithmetic shift amount: upper bits must be a sign extension of imm[4]
        imm_bad = (imm[31:4] != '1) && (imm[31:4] != '0);
      end else begin
        imm_bad = |imm[31:5];
      end
      enc_word = {funct7, imm[4:0], rs1, f3, rd, 7'b0010011};
    end else if (opcode <= 8'd32) begin
      if (opcode == 8'd24 || opcode == 8'd30) funct7 = 7'b0100000;
      enc_word = {funct7, rs2, rs1, f3, rd, 7'b0110011};
    end else if (opcode <= 8'd35) begin
      enc_word = {17'b0, f3, 5'b0, 7'b0001111};
    end else if (opcode == 8'd36) begin
      enc_word = {imm[21:2], rd, 7'b1101111};
      imm_bad  = (|imm[31:22]) | (|imm[1:0]);
    end else if (opcode == 8'd37) begin
      enc_word = {imm[13:2], rs1, f3, rd, 7'b1100111};
      imm_bad  = (|imm[31:14]) | (|imm[1:0]);
    end else if (opcode == 8'd38) begin
      enc_word = {imm[31:12], rd, 7'b0110111};
      imm_bad  = |imm[11:0];
    end else if (opcode == 8'd39) begin
      enc_word = {imm[31:12], rd, 7'b0010111};
      imm_bad  = |imm[11:0];
    end else if (opcode == 8'd40) begin
      enc_word = {imm[28:18], imm[12:7], f3, imm[6:2], 7'b1110011};
      imm_bad  = (|imm[31:29]) | (|imm[17:13]) | (|imm[1:0]);
    end else if (opcode <= 8'd42) begin
      enc_word = {17'b0, f3, 5'b0, 7'b1110011};
    end else begin
      op_bad = 1'b1;
    end
  end

  assign new_entry = '{terr: op_bad | imm_bad, tlast: s_tlast,
                       warp: warp_id_in, word: enc_word};

  assign s_tready = (count_q < CNT_FULL);
  assign m_tvalid = (count_q != '0);
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;

  // Buffer storage: one register per entry, written when the write pointer selects it
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    entry_t entry_q, entry_d;

    // Capture the encoded word on a push into this slot
    always_comb begin
      entry_d = entry_q;
      if (push && (wr_ptr_q == PTR_W'(gi))) entry_d = new_entry;
    end

    // Entry register, cleared on reset
    always_ff @(posedge clk) begin
      if (rst) entry_q <= '0;
      else     entry_q <= entry_d;
    end

    assign rd_arr[gi] = entry_q;
  end

  // Pointer, occupancy, sticky error and head-register next-state logic
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    out_d    = out_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (push) begin
      if (op_bad)       err_d = 32'h1;
      else if (imm_bad) err_d = 32'h2;
    end
    // The head register only moves when a new head exists; an incoming word
    // that lands exactly at the new head is bypassed straight in. When the
    // buffer drains, the last read entry is left on the outputs.
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) out_d = new_entry;
      else                                out_d = rd_arr[rd_ptr_d];
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      out_q    <= out_d;
    end
  end

  assign instruction = out_q.word;
  assign warp_id_out = out_q.warp;
  assign m_tlast     = out_q.tlast;
  assign m_terr      = out_q.terr;
  assign err         = err_q;

endmodule

// File: tb/tb_inst_encode.sv
// Scoreboard bench for inst_encode: the driver queues the hand-computed
// expected word on every input handshake, the monitor pops and compares on
// every output handshake.
module tb_inst_encode;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic [4:0]  warp_id_in;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] instruction;
  logic [4:0]  warp_id_out;
  logic        m_tlast;
  logic        m_terr;
  logic [31:0] err;

  typedef struct {
    logic [31:0] word;
    logic        terr;
    logic        tlast;
    logic [4:0]  warp;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  inst_encode #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .warp_id_in(warp_id_in), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .instruction(instruction), .warp_id_out(warp_id_out),
    .m_tlast(m_tlast), .m_terr(m_terr), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive one micro-op (called just after a rising edge) and wait for acceptance
  task automatic send(input logic [7:0] op, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                      input logic [4:0] rs2_v, input logic [31:0] imm_v, input logic [4:0] w,
                      input logic t, input logic [31:0] exp_word, input logic exp_terr);
    bit accepted = 0;
    exp_t e;
    opcode = op; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; imm = imm_v;
    warp_id_in = w; s_tlast = t; s_tvalid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (s_tready) accepted = 1;
    end
    if (!accepted) begin
      chk("accept_timeout", 32'(s_tready), 32'h1);
      s_tvalid = 1'b0;
      return;
    end
    e.word = exp_word; e.terr = exp_terr; e.tlast = t; e.warp = w;
    exp_q.push_back(e);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    $display("send op=%0d imm=%h -> expect word=%h terr=%0b", op, imm_v, exp_word, exp_terr);
    chk("valid_after_accept", 32'(m_tvalid), 32'h1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every word the DUT hands over against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", instruction, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          $display("recv word=%h terr=%0b warp=%0d tlast=%0b (expected %h)",
                   instruction, m_terr, warp_id_out, m_tlast, e.word);
          chk("word", instruction, e.word);
          chk("terr", 32'(m_terr), 32'(e.terr));
          chk("tlast", 32'(m_tlast), 32'(e.tlast));
          chk("warp", 32'(warp_id_out), 32'(e.warp));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; warp_id_in = '0; s_tlast = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'h0);
    chk("rst_s_tready", 32'(s_tready), 32'h1);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_m_terr", 32'(m_terr), 32'h0);
    chk("rst_m_tlast", 32'(m_tlast), 32'h0);
    chk("rst_warp", 32'(warp_id_out), 32'h0);
    chk("rst_err", err, 32'h0);
    idle(1);

    // Streaming with the sink always ready (back-to-back push/pop)
    m_tready = 1'b1;
    send(8'd23, 5'd3, 5'd1, 5'd2, 32'h0, 5'd0, 1'b0, 32'h002081B3, 1'b0);
    // branch: [11:7]=imm[6:2]=2, rs2=6, rs1=5
    send(8'd0, 5'd0, 5'd5, 5'd6, 32'h0000_0008, 5'd1, 1'b0, 32'h00628163, 1'b0);
    send(8'd11, 5'd0, 5'd3, 5'd4, 32'h0000_07FF, 5'd2, 1'b0, 32'h7E418FA3, 1'b0);
    send(8'd30, 5'd1, 5'd2, 5'd3, 32'h0, 5'd3, 1'b0, 32'h403150B3, 1'b0);
    send(8'd10, 5'd5, 5'd6, 5'd0, 32'h0000_0FFF, 5'd4, 1'b0, 32'hFFF35283, 1'b0);
    send(8'd36, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 5'd5, 1'b0, 32'h002000EF, 1'b0);
    send(8'd40, 5'd0, 5'd0, 5'd0, 32'h0004_0084, 5'd6, 1'b0, 32'h0020D0F3, 1'b0);
    chk("err_clean", err, 32'h0);

    // Illegal opcode, then sticky behaviour
    send(8'd50, 5'd1, 5'd1, 5'd1, 32'h0, 5'd7, 1'b1, 32'h0, 1'b1);
    chk("err_opcode", err, 32'h1);
    send(8'd42, 5'd7, 5'd7, 5'd0, 32'h0, 5'd8, 1'b0, 32'h00007073, 1'b0);
    chk("err_sticky1", err, 32'h1);

    // Illegal immediates overwrite the code
    send(8'd14, 5'd1, 5'd2, 5'd0, 32'h0000_0040, 5'd9, 1'b0, 32'h00010093, 1'b1);
    chk("err_imm", err, 32'h2);
    send(8'd22, 5'd4, 5'd5, 5'd0, 32'hFFFF_FFF3, 5'd10, 1'b0, 32'h4132D213, 1'b0);
    send(8'd38, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 5'd11, 1'b0, 32'h12345137, 1'b0);
    send(8'd38, 5'd2, 5'd0, 5'd0, 32'h1234_5001, 5'd12, 1'b1, 32'h12345137, 1'b1);
    chk("err_sticky2", err, 32'h2);
    send(8'd43, 5'd0, 5'd0, 5'd0, 32'h0, 5'd13, 1'b0, 32'h0, 1'b1);
    chk("err_overwrite", err, 32'h1);
    idle(3);

    // Backpressure: two words fill the buffer, head held stable
    m_tready = 1'b0;
    send(8'd23, 5'd3, 5'd1, 5'd2, 32'h0, 5'd20, 1'b0, 32'h002081B3, 1'b0);
    chk("ready_one_entry", 32'(s_tready), 32'h1);
    send(8'd30, 5'd1, 5'd2, 5'd3, 32'h0, 5'd21, 1'b0, 32'h403150B3, 1'b0);
    chk("ready_full", 32'(s_tready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_word", instruction, 32'h002081B3);
      chk("hold_warp", 32'(warp_id_out), 32'd20);
      chk("hold_ready", 32'(s_tready), 32'h0);
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    send(8'd42, 5'd7, 5'd7, 5'd0, 32'h0, 5'd22, 1'b1, 32'h00007073, 1'b0);
    idle(4);
    chk("drained", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
    chk("empty_last_word", instruction, 32'h00007073);
    chk("empty_valid", 32'(m_tvalid), 32'h0);
    @(posedge clk); #1;

    // Reset with two words buffered: nothing may come out
    m_tready = 1'b0;
    send(8'd23, 5'd3, 5'd1, 5'd2, 32'h0, 5'd1, 1'b0, 32'h002081B3, 1'b0);
    send(8'd50, 5'd0, 5'd0, 5'd0, 32'h0, 5'd2, 1'b0, 32'h0, 1'b1);
    chk("pre_rst_err", err, 32'h1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(m_tvalid), 32'h0);
    chk("mid_rst_err", err, 32'h0);
    chk("mid_rst_ready", 32'(s_tready), 32'h1);
    chk("mid_rst_word", instruction, 32'h0);
    @(posedge clk); #1;
    m_tready = 1'b1;
    idle(3);
    send(8'd0, 5'd0, 5'd5, 5'd6, 32'h0000_0008, 5'd3, 1'b1, 32'h00628163, 1'b0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    idle(1);
    chk("final_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
